// File: rtl/decoder_scan_ctrl_if.sv
// ----------------------------------------------------------------------------
// decoder_scan_ctrl_if
//   Groups the controller-facing handshake and the decoder-facing drive of the
//   channel scan sequencer into one bundle.
//
//   Controller -> sequencer : start, stop, cont, chan_mask[15:0]
//   Sequencer  -> decoder   : en_n (active low), S[3:0]
//   Sequencer  -> controller: busy, done, chan_strobe
//
//   modport master : the controller side (drives requests, observes status)
//   modport slave  : the sequencer itself
// ----------------------------------------------------------------------------
interface decoder_scan_ctrl_if;
   logic        start;
   logic        stop;
   logic        cont;
   logic [15:0] chan_mask;
   logic        en_n;
   logic [3:0]  S;
   logic        busy;
   logic        done;
   logic        chan_strobe;

   modport master (
      output start, stop, cont, chan_mask,
      input  en_n, S, busy, done, chan_strobe
   );

   modport slave (
      input  start, stop, cont, chan_mask,
      output en_n, S, busy, done, chan_strobe
   );
endinterface

// File: rtl/decoder_scan_ctrl.sv
// ----------------------------------------------------------------------------
// decoder_scan_ctrl
//   Sequencer sitting directly in front of a 4-to-16 decoder. On a start
//   request it walks channels 0..15, holding each one enabled (en_n=0) for
//   DWELL cycles, with GAP blanking cycles (en_n=1) between channels. Runs a
//   single sweep or scans continuously until stopped.
//
// Parameters
//   DWELL : cycles each channel is enabled (1 .. 2**CW-1)
//   GAP   : blanking cycles between channels (0 = back to back)
//   CW    : width of the dwell/gap counter
//
// Ports
//   clk    : rising-edge clock
//   reset  : synchronous, active-high reset
//   bus    : decoder_scan_ctrl_if.slave
//              in : start, stop, cont, chan_mask[15:0]
//              out: en_n, S[3:0], busy, done, chan_strobe (all registered)
//
// Build option
//   SCAN_MASK_EN : when defined, chan_mask is captured at start and channels
//                  with a clear mask bit are skipped entirely. When undefined,
//                  chan_mask is ignored and all 16 channels are visited.
// ----------------------------------------------------------------------------
module decoder_scan_ctrl #(
   parameter int DWELL = 4,
   parameter int GAP   = 1,
   parameter int CW    = 8
) (
   input  logic                clk,
   input  logic                reset,
   decoder_scan_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACTIVE,
      ST_BLANK,
      ST_DONE
   } state_t;

   // Terminal counts; the counter runs 0..N-1 within a state.
   localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
   localparam logic [CW-1:0] GAP_LAST   = (GAP > 0) ? CW'(GAP - 1) : '0;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    chan_q, chan_d;
   logic          cont_q, cont_d;
   logic [15:0]   mask_q, mask_d;
   logic          en_n_q, en_n_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          strobe_q, strobe_d;

   logic [15:0]   mask_start;
   logic [4:0]    first_ch;
   logic [4:0]    next_ch;
   logic [4:0]    wrap_ch;
   logic          hop;
   logic [3:0]    hop_ch;

`ifdef SCAN_MASK_EN
   assign mask_start = bus.chan_mask;
`else
   // The port stays for drop-in compatibility; forcing all ones visits every channel.
   assign mask_start = bus.chan_mask | 16'hFFFF;
`endif

   // Lowest set bit of m at index >= from. Returns {found, index}.
   function automatic logic [4:0] next_set(input logic [15:0] m, input logic [4:0] from);
      logic [4:0] r;
      r = '0;
      for (int i = 15; i >= 0; i--) begin
         if (m[i] && (5'(i) >= from)) r = {1'b1, 4'(i)};
      end
      return r;
   endfunction

   assign first_ch = next_set(mask_start, 5'd0);
   assign next_ch  = next_set(mask_q, {1'b0, chan_q} + 5'd1);
   assign wrap_ch  = next_set(mask_q, 5'd0);

   // NOTE: every signal written here gets a default first, so no path leaves a
   // value unassigned and no latch is inferred.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q + 1'b1;
      chan_d   = chan_q;
      cont_d   = cont_q;
      mask_d   = mask_q;
      strobe_d = 1'b0;
      hop      = 1'b0;
      hop_ch   = chan_q;

      unique case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            // stop has priority over start in the same cycle
            if (bus.start && !bus.stop) begin
               cont_d = bus.cont;
               mask_d = mask_start;
               if (first_ch[4]) begin
                  state_d  = ST_ACTIVE;
                  chan_d   = first_ch[3:0];
                  strobe_d = 1'b1;
               end else if (!bus.cont) begin
                  // empty mask, single sweep: report completion immediately
                  state_d = ST_DONE;
               end
            end
         end

         ST_ACTIVE: begin
            if (bus.stop) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == DWELL_LAST) begin
               cnt_d = '0;
               if (next_ch[4]) begin
                  hop    = 1'b1;
                  hop_ch = next_ch[3:0];
               end else if (cont_q) begin
                  // current channel is enabled, so the wrap search always hits
                  hop    = 1'b1;
                  hop_ch = wrap_ch[3:0];
               end else begin
                  state_d = ST_DONE;
               end
               if (hop) begin
                  // S moves at the channel boundary so it is stable while en_n=0
                  chan_d = hop_ch;
                  if (GAP > 0) begin
                     state_d = ST_BLANK;
                  end else begin
                     state_d  = ST_ACTIVE;
                     strobe_d = 1'b1;
                  end
               end
            end
         end

         ST_BLANK: begin
            if (bus.stop) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == GAP_LAST) begin
               state_d  = ST_ACTIVE;
               cnt_d    = '0;
               strobe_d = 1'b1;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end

         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase

      // Outputs are registered versions of the upcoming state.
      en_n_d = (state_d != ST_ACTIVE);
      busy_d = (state_d == ST_ACTIVE) || (state_d == ST_BLANK);
      done_d = (state_d == ST_DONE);
   end

   // NOTE: sequential state uses non-blocking assignments so all registers
   // update together from values sampled at the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         chan_q   <= '0;
         cont_q   <= 1'b0;
         mask_q   <= '0;
         en_n_q   <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         strobe_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         chan_q   <= chan_d;
         cont_q   <= cont_d;
         mask_q   <= mask_d;
         en_n_q   <= en_n_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         strobe_q <= strobe_d;
      end
   end

   assign bus.en_n        = en_n_q;
   assign bus.S           = chan_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.chan_strobe = strobe_q;

endmodule
